// File: rtl/fetch_unit.sv
// Instruction-fetch requester: walks the PC over the shared memory, assembles
// 1-byte and 2-byte (opcode + immediate) instructions and presents them to decode.
module fetch_unit #(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_VEC  = 8'd0,
   parameter logic [3:0]            LONG_OPC   = 4'hC
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] I_addr,
   input  logic [DATA_WIDTH-1:0] I_data,
   input  logic                  stall,
   input  logic                  branch_en,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  instr_long,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [ADDR_WIDTH-1:0] pc_next
);

   typedef enum logic {FETCH_OP, FETCH_IMM} state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] pc, pc_d;
   logic [DATA_WIDTH-1:0] op_buf, op_buf_d;
   logic [ADDR_WIDTH-1:0] op_pc, op_pc_d;
   logic [DATA_WIDTH-1:0] instr_d, imm_d;
   logic                  instr_long_d, instr_valid_d;
   logic [ADDR_WIDTH-1:0] pc_out_d, pc_next_d;
   logic                  hold, is_long;

   assign I_addr  = pc;
   assign hold    = instr_valid && stall;
   assign is_long = (I_data[DATA_WIDTH-1 -: 4] == LONG_OPC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH_OP;
         pc          <= RESET_VEC;
         op_buf      <= '0;
         op_pc       <= '0;
         instr       <= '0;
         imm         <= '0;
         instr_long  <= 1'b0;
         instr_valid <= 1'b0;
         pc_out      <= '0;
         pc_next     <= '0;
      end else begin
         state       <= state_d;
         pc          <= pc_d;
         op_buf      <= op_buf_d;
         op_pc       <= op_pc_d;
         instr       <= instr_d;
         imm         <= imm_d;
         instr_long  <= instr_long_d;
         instr_valid <= instr_valid_d;
         pc_out      <= pc_out_d;
         pc_next     <= pc_next_d;
      end
   end

   always_comb begin
      state_d       = state;
      pc_d          = pc;
      op_buf_d      = op_buf;
      op_pc_d       = op_pc;
      instr_d       = instr;
      imm_d         = imm;
      instr_long_d  = instr_long;
      instr_valid_d = instr_valid;
      pc_out_d      = pc_out;
      pc_next_d     = pc_next;

      // A redirect abandons any half-assembled long instruction.
      if (branch_en) begin
         pc_d          = branch_addr;
         state_d       = FETCH_OP;
         instr_valid_d = 1'b0;
      end else if (state == FETCH_IMM) begin
         instr_d       = op_buf;
         imm_d         = I_data;
         instr_long_d  = 1'b1;
         pc_out_d      = op_pc;
         pc_next_d     = op_pc + TWO;
         instr_valid_d = 1'b1;
         pc_d          = pc + ONE;
         state_d       = FETCH_OP;
      end else if (!hold) begin
         if (is_long) begin
            op_buf_d      = I_data;
            op_pc_d       = pc;
            pc_d          = pc + ONE;
            instr_valid_d = 1'b0;
            state_d       = FETCH_IMM;
         end else begin
            instr_d       = I_data;
            imm_d         = '0;
            instr_long_d  = 1'b0;
            pc_out_d      = pc;
            pc_next_d     = pc + ONE;
            instr_valid_d = 1'b1;
            pc_d          = pc + ONE;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against
// an instruction-level model that walks memory one instruction at a time.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] I_addr, I_data;
   logic       stall = 1'b0, branch_en = 1'b0;
   logic [7:0] branch_addr = '0;
   logic [7:0] instr, imm, pc_out, pc_next;
   logic       instr_long, instr_valid;

   logic [7:0] mem [256];
   int checks = 0;
   int errors = 0;

   // Model: next instruction address, cycles already spent on it, presented outputs.
   logic [7:0] m_na;
   int         m_el;
   logic       m_valid;
   logic [7:0] m_instr, m_imm, m_pc_out, m_pc_next;
   logic       m_long;

   fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_VEC(8'd0), .LONG_OPC(4'hC)) dut (
      .clk(clk), .rst(rst), .I_addr(I_addr), .I_data(I_data), .stall(stall),
      .branch_en(branch_en), .branch_addr(branch_addr), .instr(instr), .imm(imm),
      .instr_long(instr_long), .instr_valid(instr_valid), .pc_out(pc_out), .pc_next(pc_next)
   );

   assign I_data = mem[I_addr];

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input logic r, input logic s, input logic be, input logic [7:0] ba);
      logic [7:0] op;
      int         len;
      rst = r; stall = s; branch_en = be; branch_addr = ba;
      @(posedge clk);
      if (r) begin
         m_na = 8'h00; m_el = 0; m_valid = 1'b0;
         m_instr = '0; m_imm = '0; m_long = 1'b0; m_pc_out = '0; m_pc_next = '0;
      end else if (be) begin
         m_na = ba; m_el = 0; m_valid = 1'b0;
      end else if (!(m_valid && s)) begin
         op  = mem[m_na];
         len = (op[7:4] == 4'hC) ? 2 : 1;
         if (m_el + 1 == len) begin
            m_instr   = op;
            m_imm     = (len == 2) ? mem[8'(m_na + 8'd1)] : 8'h00;
            m_long    = (len == 2);
            m_pc_out  = m_na;
            m_pc_next = 8'(m_na + 8'(len));
            m_valid   = 1'b1;
            m_na      = 8'(m_na + 8'(len));
            m_el      = 0;
         end else begin
            m_el    = m_el + 1;
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic test_reset();
      clear_mem();
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      checks++;
      if ({I_addr, instr_valid, instr, imm, pc_next, pc_out, instr_long} !== {8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got addr=%h v=%b instr=%h imm=%h pcn=%h pco=%h long=%b, expected all zero",
                  I_addr, instr_valid, instr, imm, pc_next, pc_out, instr_long);
      end
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, instr, pc_out} !== {1'b1, 8'h11, 8'h00}) begin
         errors++;
         $display("FAIL reset_first: got v=%b instr=%h pco=%h, expected v=1 instr=11 pco=00",
                  instr_valid, instr, pc_out);
      end
   endtask

   task automatic test_short();
      logic [7:0] exp_i [3];
      exp_i[0] = 8'h11; exp_i[1] = 8'h22; exp_i[2] = 8'h33;
      tick(1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, 0, 0);
         checks++;
         if ({instr_valid, instr, imm, instr_long, pc_out, pc_next} !== {1'b1, exp_i[k], 8'h00, 1'b0, 8'(k), 8'(k + 1)}) begin
            errors++;
            $display("FAIL short_%0d: got v=%b instr=%h imm=%h long=%b pco=%h pcn=%h, expected v=1 instr=%h imm=00 long=0 pco=%h pcn=%h",
                     k, instr_valid, instr, imm, instr_long, pc_out, pc_next, exp_i[k], 8'(k), 8'(k + 1));
         end
      end
   endtask

   task automatic test_stall();
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         tick(0, 1, 0, 0);
         checks++;
         if ({instr_valid, instr, pc_out, pc_next, I_addr} !== {1'b1, 8'h22, 8'h01, 8'h02, 8'h02}) begin
            errors++;
            $display("FAIL stall_hold_%0d: got v=%b instr=%h pco=%h pcn=%h addr=%h, expected v=1 instr=22 pco=01 pcn=02 addr=02",
                     k, instr_valid, instr, pc_out, pc_next, I_addr);
         end
      end
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, instr, pc_out} !== {1'b1, 8'h33, 8'h02}) begin
         errors++;
         $display("FAIL stall_release: got v=%b instr=%h pco=%h, expected v=1 instr=33 pco=02",
                  instr_valid, instr, pc_out);
      end
   endtask

   task automatic test_long();
      clear_mem();
      mem[0] = 8'hC5; mem[1] = 8'h7A; mem[2] = 8'h10;
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, I_addr} !== {1'b0, 8'h01}) begin
         errors++;
         $display("FAIL long_bubble: got v=%b addr=%h, expected v=0 addr=01", instr_valid, I_addr);
      end
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, instr, imm, instr_long, pc_out, pc_next} !== {1'b1, 8'hC5, 8'h7A, 1'b1, 8'h00, 8'h02}) begin
         errors++;
         $display("FAIL long_present: got v=%b instr=%h imm=%h long=%b pco=%h pcn=%h, expected v=1 instr=C5 imm=7A long=1 pco=00 pcn=02",
                  instr_valid, instr, imm, instr_long, pc_out, pc_next);
      end
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, instr, instr_long, pc_out} !== {1'b1, 8'h10, 1'b0, 8'h02}) begin
         errors++;
         $display("FAIL long_follow: got v=%b instr=%h long=%b pco=%h, expected v=1 instr=10 long=0 pco=02",
                  instr_valid, instr, instr_long, pc_out);
      end
   endtask

   task automatic test_branch();
      clear_mem();
      mem[0] = 8'hC5; mem[1] = 8'h7A; mem[8'h40] = 8'h55;
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 1, 1, 8'h40);
      checks++;
      if ({instr_valid, I_addr} !== {1'b0, 8'h40}) begin
         errors++;
         $display("FAIL branch_redirect: got v=%b addr=%h, expected v=0 addr=40", instr_valid, I_addr);
      end
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, instr, imm, instr_long, pc_out, pc_next} !== {1'b1, 8'h55, 8'h00, 1'b0, 8'h40, 8'h41}) begin
         errors++;
         $display("FAIL branch_target: got v=%b instr=%h imm=%h long=%b pco=%h pcn=%h, expected v=1 instr=55 imm=00 long=0 pco=40 pcn=41",
                  instr_valid, instr, imm, instr_long, pc_out, pc_next);
      end
   endtask

   task automatic test_wrap();
      clear_mem();
      mem[8'hFF] = 8'hC1; mem[0] = 8'h99;
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 0, 1, 8'hFF);
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, I_addr} !== {1'b0, 8'h00}) begin
         errors++;
         $display("FAIL wrap_bubble: got v=%b addr=%h, expected v=0 addr=00", instr_valid, I_addr);
      end
      tick(0, 0, 0, 0);
      checks++;
      if ({instr_valid, instr, imm, instr_long, pc_out, pc_next, I_addr} !== {1'b1, 8'hC1, 8'h99, 1'b1, 8'hFF, 8'h01, 8'h01}) begin
         errors++;
         $display("FAIL wrap_present: got v=%b instr=%h imm=%h long=%b pco=%h pcn=%h addr=%h, expected v=1 instr=C1 imm=99 long=1 pco=FF pcn=01 addr=01",
                  instr_valid, instr, imm, instr_long, pc_out, pc_next, I_addr);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic [7:0] exp_addr;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) b[7:4] = 4'hC;
         mem[i] = b;
      end
      tick(1, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         tick($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 19) == 0, 8'($urandom));
         exp_addr = 8'(m_na + 8'(m_el));
         checks++;
         if (I_addr !== exp_addr || instr_valid !== m_valid ||
             (m_valid && {instr, imm, instr_long, pc_out, pc_next} !== {m_instr, m_imm, m_long, m_pc_out, m_pc_next})) begin
            errors++;
            $display("FAIL random_%0d: got addr=%h v=%b instr=%h imm=%h long=%b pco=%h pcn=%h, expected addr=%h v=%b instr=%h imm=%h long=%b pco=%h pcn=%h",
                     n, I_addr, instr_valid, instr, imm, instr_long, pc_out, pc_next,
                     exp_addr, m_valid, m_instr, m_imm, m_long, m_pc_out, m_pc_next);
         end
      end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_short();
      test_stall();
      test_long();
      test_branch();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
